// File: rtl/select_de_multi.sv
// NdX die selector: edge-detected buttons pick die type and count, then a
// sequential add/double-dabble engine produces min/max totals and the display.
module select_de_multi #(
  parameter int NB_MAX  = 9,
  parameter int W_TOT   = 10,
  parameter int ID_INIT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             suivant,
  input  logic             precedent,
  input  logic             plus_nb,
  input  logic             moins_nb,
  output logic [W_TOT-1:0] min_tot,
  output logic [W_TOT-1:0] max_tot,
  output logic [3:0]       nb_de,
  output logic [2:0]       id_de,
  output logic             occupe,
  output logic             pret,
  output logic [6:0]       hex_nb,
  output logic [6:0]       hex_d,
  output logic [6:0]       hex100,
  output logic [6:0]       hex10,
  output logic [6:0]       hex1
);

  typedef enum logic [1:0] {IDLE, MUL, BCD, MAJ} state_t;

  localparam int         DW        = W_TOT + 12;
  localparam int         CW        = $clog2(W_TOT + 1);
  localparam logic [6:0] BLANK     = 7'b1111111;
  localparam logic [6:0] GLYPH_D   = 7'b0100001;
  localparam logic [3:0] NB_MAX_L  = 4'(NB_MAX);
  localparam logic [2:0] ID_INIT_L = 3'(ID_INIT);

  function automatic logic [W_TOT-1:0] faces(input logic [2:0] id);
    case (id)
      3'd0:    return W_TOT'(2);
      3'd1:    return W_TOT'(4);
      3'd2:    return W_TOT'(6);
      3'd3:    return W_TOT'(8);
      3'd4:    return W_TOT'(10);
      3'd5:    return W_TOT'(12);
      3'd6:    return W_TOT'(20);
      default: return W_TOT'(100);
    endcase
  endfunction

  // One double-dabble step: adjust each BCD digit >= 5, then shift left.
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] v);
    logic [DW-1:0] t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      if (t[W_TOT+4*i +: 4] >= 4'd5) t[W_TOT+4*i +: 4] = t[W_TOT+4*i +: 4] + 4'd3;
    end
    return {t[DW-2:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  state_t           state_q;
  logic             prev_s_q, prev_p_q, prev_plus_q, prev_moins_q;
  logic [2:0]       id_q, id_d;
  logic [3:0]       nb_q, nb_d;
  logic             relance_q;
  logic [W_TOT-1:0] faces_q, acc_q, acc_nx;
  logic [3:0]       snap_nb_q, k_q;
  logic [DW-1:0]    dd_q;
  logic [CW-1:0]    cnt_q;
  logic [W_TOT-1:0] min_q, max_q;
  logic             pret_q;
  logic [6:0]       hex_nb_q, hex_d_q, hex100_q, hex10_q, hex1_q;
  logic             ev_s, ev_p, ev_plus, ev_moins, ev_any;
  logic [3:0]       dig_h, dig_t, dig_o;

  always_comb begin
    ev_s     = suivant   & ~prev_s_q;
    ev_p     = precedent & ~prev_p_q;
    ev_plus  = plus_nb   & ~prev_plus_q;
    ev_moins = moins_nb  & ~prev_moins_q;
    // Opposing events in the same cycle cancel and start no computation.
    ev_any   = (ev_s ^ ev_p) | (ev_plus ^ ev_moins);
    id_d = id_q;
    if (ev_s && !ev_p)      id_d = id_q + 3'd1;
    else if (ev_p && !ev_s) id_d = id_q - 3'd1;
    nb_d = nb_q;
    if (ev_plus && !ev_moins && nb_q < NB_MAX_L)   nb_d = nb_q + 4'd1;
    else if (ev_moins && !ev_plus && nb_q > 4'd1)  nb_d = nb_q - 4'd1;
    acc_nx = acc_q + faces_q;
    dig_h  = dd_q[DW-1 -: 4];
    dig_t  = dd_q[DW-5 -: 4];
    dig_o  = dd_q[DW-9 -: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_s_q     <= 1'b1;
      prev_p_q     <= 1'b1;
      prev_plus_q  <= 1'b1;
      prev_moins_q <= 1'b1;
      id_q         <= ID_INIT_L;
      nb_q         <= 4'd1;
      relance_q    <= 1'b0;
      pret_q       <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      hex_nb_q     <= BLANK;
      hex_d_q      <= BLANK;
      hex100_q     <= BLANK;
      hex10_q      <= BLANK;
      hex1_q       <= BLANK;
      state_q      <= MUL;
      faces_q      <= faces(ID_INIT_L);
      snap_nb_q    <= 4'd1;
      k_q          <= 4'd1;
      acc_q        <= '0;
      dd_q         <= '0;
      cnt_q        <= '0;
    end else begin
      prev_s_q     <= suivant;
      prev_p_q     <= precedent;
      prev_plus_q  <= plus_nb;
      prev_moins_q <= moins_nb;
      id_q         <= id_d;
      nb_q         <= nb_d;
      case (state_q)
        IDLE: begin
          if (ev_any) begin
            state_q   <= MUL;
            faces_q   <= faces(id_d);
            snap_nb_q <= nb_d;
            k_q       <= nb_d;
            acc_q     <= '0;
          end
        end
        MUL: begin
          acc_q <= acc_nx;
          k_q   <= k_q - 4'd1;
          if (k_q == 4'd1) begin
            state_q <= BCD;
            dd_q    <= {12'b0, acc_nx};
            cnt_q   <= CW'(W_TOT - 1);
          end
          if (ev_any) relance_q <= 1'b1;
        end
        BCD: begin
          dd_q <= dd_step(dd_q);
          if (cnt_q == '0) state_q <= MAJ;
          else             cnt_q   <= cnt_q - 1'b1;
          if (ev_any) relance_q <= 1'b1;
        end
        MAJ: begin
          max_q    <= acc_q;
          min_q    <= W_TOT'(snap_nb_q);
          pret_q   <= 1'b1;
          hex_nb_q <= seg7(snap_nb_q);
          hex_d_q  <= GLYPH_D;
          hex100_q <= (dig_h == 4'd0) ? BLANK : seg7(dig_h);
          hex10_q  <= (dig_h == 4'd0 && dig_t == 4'd0) ? BLANK : seg7(dig_t);
          hex1_q   <= seg7(dig_o);
          // A pending or same-cycle event restarts straight from MAJ.
          if (relance_q || ev_any) begin
            state_q   <= MUL;
            faces_q   <= faces(id_d);
            snap_nb_q <= nb_d;
            k_q       <= nb_d;
            acc_q     <= '0;
            relance_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign min_tot = min_q;
  assign max_tot = max_q;
  assign nb_de   = nb_q;
  assign id_de   = id_q;
  assign occupe  = (state_q != IDLE);
  assign pret    = pret_q;
  assign hex_nb  = hex_nb_q;
  assign hex_d   = hex_d_q;
  assign hex100  = hex100_q;
  assign hex10   = hex10_q;
  assign hex1    = hex1_q;

endmodule

// File: tb/tb_select_de_multi.sv
// Directed bench for select_de_multi: a button-level model of die/count and
// arithmetic totals, checked every idle cycle, plus hand-computed literals.
module tb_select_de_multi;

  logic       clk = 1'b0;
  logic       reset, suivant, precedent, plus_nb, moins_nb;
  logic [9:0] min_tot, max_tot;
  logic [3:0] nb_de;
  logic [2:0] id_de;
  logic       occupe, pret;
  logic [6:0] hex_nb, hex_d, hex100, hex10, hex1;

  select_de_multi dut (
    .clk(clk), .reset(reset), .suivant(suivant), .precedent(precedent),
    .plus_nb(plus_nb), .moins_nb(moins_nb), .min_tot(min_tot), .max_tot(max_tot),
    .nb_de(nb_de), .id_de(id_de), .occupe(occupe), .pret(pret),
    .hex_nb(hex_nb), .hex_d(hex_d), .hex100(hex100), .hex10(hex10), .hex1(hex1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int model_id = 0;
  int model_nb = 1;
  bit chk_en = 1'b0;
  int face_tab[8] = '{2, 4, 6, 8, 10, 12, 20, 100};

  localparam logic [6:0] BL = 7'b1111111;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BL;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Model-driven check on every settled cycle.
  always @(negedge clk) begin
    if (chk_en && !reset && !occupe && pret) begin
      int mx, h, t, o;
      mx = model_nb * face_tab[model_id];
      h = mx / 100; t = (mx / 10) % 10; o = mx % 10;
      chk("model id_de", 32'(id_de), 32'(model_id));
      chk("model nb_de", 32'(nb_de), 32'(model_nb));
      chk("model min_tot", 32'(min_tot), 32'(model_nb));
      chk("model max_tot", 32'(max_tot), 32'(mx));
      chk("model hex_nb", 32'(hex_nb), 32'(seg(model_nb)));
      chk("model hex_d", 32'(hex_d), 32'(7'b0100001));
      chk("model hex100", 32'(hex100), 32'((h == 0) ? BL : seg(h)));
      chk("model hex10", 32'(hex10), 32'((h == 0 && t == 0) ? BL : seg(t)));
      chk("model hex1", 32'(hex1), 32'(seg(o)));
    end
  end

  task automatic press(input int which);
    chk_en = 1'b0;
    @(posedge clk); #1;
    case (which)
      0: begin suivant = 1'b1;   model_id = (model_id + 1) % 8; end
      1: begin precedent = 1'b1; model_id = (model_id + 7) % 8; end
      2: begin plus_nb = 1'b1;   if (model_nb < 9) model_nb++; end
      default: begin moins_nb = 1'b1; if (model_nb > 1) model_nb--; end
    endcase
    @(posedge clk); #1;
    suivant = 1'b0; precedent = 1'b0; plus_nb = 1'b0; moins_nb = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((occupe || !pret) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
    end
    chk_en = 1'b1;
  endtask

  task automatic press_wait(input int which, input int times);
    for (int i = 0; i < times; i++) begin
      press(which);
      wait_idle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; suivant = 1'b0; precedent = 1'b0; plus_nb = 1'b0; moins_nb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pret", 32'(pret), 0);
    chk("reset max_tot", 32'(max_tot), 0);
    chk("reset min_tot", 32'(min_tot), 0);
    chk("reset id_de", 32'(id_de), 0);
    chk("reset nb_de", 32'(nb_de), 1);
    chk("reset hex_nb", 32'(hex_nb), 32'(BL));
    chk("reset hex_d", 32'(hex_d), 32'(BL));
    chk("reset hex1", 32'(hex1), 32'(BL));
    @(posedge clk); #1 reset = 1'b0;
    wait_idle();
    chk("init max_tot", 32'(max_tot), 2);
    chk("init min_tot", 32'(min_tot), 1);
    chk("init hex_nb", 32'(hex_nb), 32'(7'b1111001));
    chk("init hex_d", 32'(hex_d), 32'(7'b0100001));
    chk("init hex100", 32'(hex100), 32'(BL));
    chk("init hex10", 32'(hex10), 32'(BL));
    chk("init hex1", 32'(hex1), 32'(7'b0100100));
    repeat (4) @(negedge clk);

    // Latency: driven in cycle t, outputs updated on edge t+nb+10+2.
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b1; model_id = 1;
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); cnt++;
      #1 suivant = 1'b0;
      if (max_tot == 10'd4) break;
    end
    chk("latency edges", 32'(cnt), 13);
    wait_idle();

    press_wait(0, 6);
    chk("d100 id_de", 32'(id_de), 7);
    chk("d100 max_tot", 32'(max_tot), 100);
    chk("d100 hex100", 32'(hex100), 32'(7'b1111001));
    chk("d100 hex10", 32'(hex10), 32'(7'b1000000));
    chk("d100 hex1", 32'(hex1), 32'(7'b1000000));
    press_wait(0, 1);
    chk("wrap up id_de", 32'(id_de), 0);
    press_wait(1, 1);
    chk("wrap down id_de", 32'(id_de), 7);

    // Opposing edges cancel.
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b1; precedent = 1'b1;
    @(posedge clk); #1 suivant = 1'b0; precedent = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cancel occupe", 32'(occupe), 0);
      chk("cancel id_de", 32'(id_de), 7);
    end
    chk_en = 1'b1;

    press_wait(2, 12);
    chk("sat nb_de", 32'(nb_de), 9);
    chk("sat max_tot", 32'(max_tot), 900);
    chk("sat min_tot", 32'(min_tot), 9);
    chk("sat hex100", 32'(hex100), 32'(7'b0010000));
    press_wait(3, 10);
    chk("floor nb_de", 32'(nb_de), 1);
    chk("floor max_tot", 32'(max_tot), 100);

    // A long hold gives exactly one event.
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b1; model_id = 0;
    repeat (50) @(posedge clk);
    #1 suivant = 1'b0;
    wait_idle();
    chk("hold50 id_de", 32'(id_de), 0);

    // Held through reset: no event until released and pressed again.
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b1; reset = 1'b1;
    model_id = 0; model_nb = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle();
    chk("held reset id_de", 32'(id_de), 0);
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b0;
    repeat (3) @(posedge clk);
    wait_idle();
    press_wait(0, 1);
    chk("after release id_de", 32'(id_de), 1);

    // Restart: d12 x3 settled, then d20 computation with nb bumped mid-flight.
    press_wait(2, 2);
    press_wait(0, 4);
    chk("pre relance max_tot", 32'(max_tot), 36);
    chk_en = 1'b0;
    @(posedge clk); #1 suivant = 1'b1; model_id = 6;
    @(posedge clk); #1 suivant = 1'b0;
    repeat (3) @(posedge clk);
    #1 plus_nb = 1'b1; model_nb = 4;
    @(posedge clk); #1 plus_nb = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (max_tot == 10'd36 && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    chk("relance first max_tot", 32'(max_tot), 60);
    chk("relance first min_tot", 32'(min_tot), 3);
    chk("relance no idle", 32'(occupe), 1);
    wait_idle();
    chk("relance final max_tot", 32'(max_tot), 80);
    chk("relance final min_tot", 32'(min_tot), 4);

    // Reset mid-computation aborts and restores reset values.
    chk_en = 1'b0;
    press(2);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_id = 0; model_nb = 1;
    @(negedge clk);
    chk("abort pret", 32'(pret), 0);
    chk("abort max_tot", 32'(max_tot), 0);
    chk("abort nb_de", 32'(nb_de), 1);
    chk("abort id_de", 32'(id_de), 0);
    chk("abort hex100", 32'(hex100), 32'(BL));
    wait_idle();
    chk("abort recompute max_tot", 32'(max_tot), 2);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
